chien_search: RTL and testbench

//  Downstream stage of the key-equation solver in the BCH decoder. Takes the error-locator

---
 rtl/chien_search.sv | 111 +++++++++++
 tb/tb_chien_search.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chien_search.sv
// chien_search: serial Chien root search of a BCH error-locator polynomial over GF(2^6/8/10)
module chien_search #(
    parameter int T = 4,
    parameter int W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_code,
    input  logic [3:0]       i_deg,
    input  logic [(T+1)*W-1:0] i_sigma,
    output logic             o_busy,
    output logic             o_err_valid,
    output logic [9:0]       o_err_pos,
    output logic [3:0]       o_err_cnt,
    output logic             o_done,
    output logic             o_fail
);
    typedef enum logic {S_IDLE, S_SRCH} state_t;
    localparam logic [3:0] T_MAX = 4'(T);
    state_t state, state_d;
    logic [1:0] code_q, sel;
    logic [3:0] deg_q, err_inc;
    logic [9:0] cnt, n, sum;
    logic [9:0] reg_q [T+1];
    logic hit, last, accept;

    function automatic logic [9:0] field_mask(input logic [1:0] c);
        return c == 2'd1 ? 10'h0FF : c == 2'd2 ? 10'h3FF : 10'h03F;
    endfunction

    function automatic logic [9:0] mul_a(input logic [9:0] x, input logic [1:0] c);
        logic top;
        logic [9:0] p;
        top = c == 2'd1 ? x[7] : c == 2'd2 ? x[9] : x[5];
        p = c == 2'd1 ? 10'h01D : c == 2'd2 ? 10'h009 : 10'h003;
        return ({x[8:0], 1'b0} ^ (top ? p : 10'h000)) & field_mask(c);
    endfunction

    // k is a constant at every call site, so each use folds into a fixed XOR network
    function automatic logic [9:0] mul_ak(input logic [9:0] x, input int k, input logic [1:0] c);
        logic [9:0] r;
        r = x;
        for (int i = 0; i < T; i++) if (i < k) r = mul_a(r, c);
        return r;
    endfunction

    assign o_busy = state == S_SRCH;

    // locator evaluation at the current candidate, sweep bookkeeping and next state
    always_comb begin
        sum = '0;
        for (int k = 0; k <= T; k++) sum ^= reg_q[k];
        sel = i_code == 2'd3 ? 2'd0 : i_code;
        n = code_q == 2'd1 ? 10'd255 : code_q == 2'd2 ? 10'd1023 : 10'd63;
        hit = sum == '0;
        last = cnt == n;
        err_inc = o_err_cnt == 4'hF ? 4'hF : o_err_cnt + 4'd1;
        accept = state == S_IDLE && i_start;
        state_d = accept && i_deg <= T_MAX ? S_SRCH : (state == S_SRCH && last ? S_IDLE : state);
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else state <= state_d;
    end

    // coefficient load, per-candidate alpha^k stepping and result reporting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            code_q <= '0;
            deg_q <= '0;
            cnt <= '0;
            for (int k = 0; k <= T; k++) reg_q[k] <= '0;
            o_err_valid <= 1'b0;
            o_err_pos <= '0;
            o_err_cnt <= '0;
            o_done <= 1'b0;
            o_fail <= 1'b0;
        end else begin
            o_err_valid <= 1'b0;
            o_done <= 1'b0;
            if (accept && i_deg <= T_MAX) begin
                code_q <= sel;
                deg_q <= i_deg;
                for (int k = 0; k <= T; k++)
                    reg_q[k] <= 4'(k) <= i_deg ? mul_ak(10'(i_sigma[k*W +: W]) & field_mask(sel), k, sel) : '0;
                cnt <= 10'd1;
                o_err_cnt <= '0;
                o_fail <= 1'b0;
            end else if (accept) begin
                o_done <= 1'b1;
                o_fail <= 1'b1;
                o_err_cnt <= '0;
            end else if (state == S_SRCH) begin
                for (int k = 0; k <= T; k++) reg_q[k] <= mul_ak(reg_q[k], k, code_q);
                cnt <= cnt + 10'd1;
                if (hit) begin
                    o_err_valid <= 1'b1;
                    o_err_pos <= last ? 10'd0 : n - cnt;
                    o_err_cnt <= err_inc;
                end
                if (last) begin
                    o_done <= 1'b1;
                    o_fail <= (hit ? err_inc : o_err_cnt) != deg_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_chien_search.sv
// tb_chien_search: random and directed checks of chien_search against a polynomial-evaluation model
module tb_chien_search;
    logic i_clk = 0, i_rst = 1, i_start = 0;
    logic [1:0] i_code = 0;
    logic [3:0] i_deg = 0;
    logic [49:0] i_sigma = 0;
    logic o_busy, o_err_valid, o_done, o_fail;
    logic [9:0] o_err_pos;
    logic [3:0] o_err_cnt;

    chien_search #(.T(4), .W(10)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_code(i_code), .i_deg(i_deg),
        .i_sigma(i_sigma), .o_busy(o_busy), .o_err_valid(o_err_valid), .o_err_pos(o_err_pos),
        .o_err_cnt(o_err_cnt), .o_done(o_done), .o_fail(o_fail)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0, n_fail = 0;
    int pq[$], cq[$], eq_pos[$], eq_cyc[$];
    int done_cyc, fin_cnt, fin_fail, busy_err, busy_done;
    int exp_done, exp_cnt, exp_fail;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int code_m(input int code);
        return code == 1 ? 8 : code == 2 ? 10 : 6;
    endfunction

    function automatic int code_poly(input int code);
        return code == 1 ? 'h11D : code == 2 ? 'h409 : 'h43;
    endfunction

    function automatic int gf_mul(input int a, input int b, input int code);
        int r = 0;
        int m = code_m(code);
        for (int i = m - 1; i >= 0; i--) begin
            r = r << 1;
            if (((r >> m) & 1) != 0) r ^= code_poly(code);
            if (((b >> i) & 1) != 0) r ^= a;
        end
        return r;
    endfunction

    function automatic int gf_pow(input int e, input int code);
        int r = 1;
        for (int i = 0; i < e; i++) r = gf_mul(r, 2, code);
        return r;
    endfunction

    // sigma(x) = prod (1 + alpha^p x) over the given error positions
    function automatic logic [49:0] from_roots(input int code, input int e, input int p0, input int p1, input int p2, input int p3);
        int c[5];
        int p[4];
        logic [49:0] s;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        c[0] = 1; c[1] = 0; c[2] = 0; c[3] = 0; c[4] = 0;
        for (int i = 0; i < e; i++)
            for (int k = i + 1; k >= 1; k--) c[k] ^= gf_mul(c[k-1], gf_pow(p[i], code), code);
        s = '0;
        for (int k = 0; k < 5; k++) s[k*10 +: 10] = 10'(c[k]);
        return s;
    endfunction

    // expected roots: direct Horner evaluation of sigma at alpha^c for every candidate c
    task automatic model(input int code, input int deg, input logic [49:0] sig);
        int cc, n, x, v;
        int s[5];
        eq_pos.delete();
        eq_cyc.delete();
        cc = code == 3 ? 0 : code;
        n = (1 << code_m(cc)) - 1;
        if (deg > 4) begin
            exp_done = 1; exp_cnt = 0; exp_fail = 1;
            return;
        end
        for (int k = 0; k < 5; k++) s[k] = k <= deg ? int'(sig[k*10 +: 10]) & n : 0;
        x = 1;
        exp_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            x = gf_mul(x, 2, cc);
            v = 0;
            for (int k = 4; k >= 0; k--) v = gf_mul(v, x, cc) ^ s[k];
            if (v == 0) begin
                eq_pos.push_back(c == n ? 0 : n - c);
                eq_cyc.push_back(c + 1);
                if (exp_cnt < 15) exp_cnt++;
            end
        end
        exp_done = n + 1;
        exp_fail = exp_cnt != deg;
    endtask

    // start in cycle 0, record pulses by cycle, return inside the o_done cycle
    task automatic run(input int code, input int deg, input logic [49:0] sig, input int xs);
        int cyc;
        pq.delete(); cq.delete();
        done_cyc = -1; busy_err = 0; busy_done = -1; fin_cnt = -1; fin_fail = -1;
        i_code = 2'(code); i_deg = 4'(deg); i_sigma = sig; i_start = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        cyc = 1;
        while (cyc <= 1100) begin
            if (o_err_valid) begin pq.push_back(int'(o_err_pos)); cq.push_back(cyc); end
            if (o_done) begin
                done_cyc = cyc; fin_cnt = o_err_cnt; fin_fail = o_fail; busy_done = o_busy;
                break;
            end
            if (!o_busy) busy_err++;
            i_start = cyc == xs;
            @(posedge i_clk); #1;
            i_start = 0;
            cyc++;
        end
    endtask

    task automatic compare(input string tag, input int code, input int deg, input logic [49:0] sig);
        model(code, deg, sig);
        check({tag, "_npulse"}, pq.size(), eq_pos.size());
        for (int i = 0; i < pq.size() && i < eq_pos.size(); i++) begin
            check({tag, "_pos"}, pq[i], eq_pos[i]);
            check({tag, "_pcyc"}, cq[i], eq_cyc[i]);
        end
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_cnt"}, fin_cnt, exp_cnt);
        check({tag, "_fail"}, fin_fail, exp_fail);
        check({tag, "_busy"}, busy_err, 0);
        check({tag, "_busy_at_done"}, busy_done, 0);
    endtask

    function automatic int first_pos();
        return pq.size() > 0 ? pq[0] : -1;
    endfunction

    function automatic int first_cyc();
        return cq.size() > 0 ? cq[0] : -1;
    endfunction

    logic [49:0] sig;
    int code, deg, e, mode, n, bad;
    int p[4];

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_outs", int'({o_busy, o_err_valid, o_err_pos, o_err_cnt, o_done, o_fail}), 0);
        i_rst = 0;

        sig = {30'd0, 10'h020, 10'h001};
        run(0, 1, sig, -1);
        check("t1_pos", first_pos(), 5);
        check("t1_cyc", first_cyc(), 59);
        check("t1_done", done_cyc, 64);
        check("t1_cnt", fin_cnt, 1);
        compare("t1", 0, 1, sig);

        sig = {30'd0, 10'h001, 10'h001};
        run(0, 1, sig, -1);
        check("t3_pos", first_pos(), 0);
        check("t3_cyc", first_cyc(), 64);
        check("t3_done", done_cyc, 64);
        compare("t3", 0, 1, sig);

        sig = {20'd0, 10'h087, 10'h07C, 10'h001};
        run(1, 2, sig, -1);
        check("t2_npulse", pq.size(), 2);
        check("t2_pos0", first_pos(), 10);
        check("t2_pos1", pq.size() > 1 ? pq[1] : -1, 3);
        check("t2_done", done_cyc, 256);
        compare("t2", 1, 2, sig);

        sig = {20'd0, 10'h000, 10'h020, 10'h001};
        run(0, 2, sig, -1);
        check("t4_pos", first_pos(), 5);
        check("t4_cnt", fin_cnt, 1);
        check("t4_fail", fin_fail, 1);
        compare("t4", 0, 2, sig);
        repeat (3) @(posedge i_clk);
        #1;
        check("hold_cnt", o_err_cnt, 1);
        check("hold_fail", o_fail, 1);
        run(0, 5, sig, -1);
        check("t4b_done", done_cyc, 1);
        compare("t4b", 0, 5, sig);

        sig = from_roots(2, 1, 1000, 0, 0, 0);
        run(2, 1, sig, 10);
        check("t5_pos", first_pos(), 1000);
        check("t5_cyc", first_cyc(), 24);
        check("t5_done", done_cyc, 1024);
        compare("t5", 2, 1, sig);

        run(0, 0, 50'd0, -1);
        check("sat_cnt", fin_cnt, 15);
        compare("sat", 0, 0, 50'd0);

        i_code = 0; i_deg = 1; i_sigma = {30'd0, 10'h020, 10'h001}; i_start = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        repeat (29) begin @(posedge i_clk); #1; end
        i_rst = 1;
        @(posedge i_clk); #1;
        i_rst = 0;
        check("t6_outs", int'({o_busy, o_err_valid, o_err_pos, o_err_cnt, o_done, o_fail}), 0);
        bad = 0;
        repeat (80) begin
            @(posedge i_clk); #1;
            if (o_done || o_err_valid) bad++;
        end
        check("t6_quiet", bad, 0);
        sig = {30'd0, 10'h020, 10'h001};
        run(0, 1, sig, -1);
        check("t6_pos", first_pos(), 5);
        compare("t6", 0, 1, sig);

        for (int it = 0; it < 12; it++) begin
            code = int'($urandom % 4);
            n = (1 << code_m(code == 3 ? 0 : code)) - 1;
            mode = int'($urandom % 3);
            e = int'($urandom_range(0, 4));
            if (mode == 0) begin
                for (int i = 0; i < 4; i++) begin
                    p[i] = int'($urandom_range(0, n - 1));
                    for (int j = 0; j < i; j++) if (p[j] == p[i]) p[i] = (p[i] + 1 + i) % n;
                end
                if (e >= 2 && p[1] == p[0]) e = 1;
                if (e >= 3 && (p[2] == p[0] || p[2] == p[1])) e = 2;
                if (e == 4 && (p[3] == p[0] || p[3] == p[1] || p[3] == p[2])) e = 3;
                sig = from_roots(code == 3 ? 0 : code, e, p[0], p[1], p[2], p[3]);
                deg = e;
            end else begin
                sig = 50'({$urandom, $urandom});
                sig[9:0] = 10'h001;
                deg = mode == 1 ? e : int'($urandom_range(5, 15));
            end
            for (int k = 0; k < 5; k++) begin
                if (k > deg) sig[k*10 +: 10] = 10'($urandom);
                sig[k*10 +: 10] = sig[k*10 +: 10] | (10'($urandom) & ~10'(n));
            end
            run(code, deg, sig, -1);
            compare("rand", code, deg, sig);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
